// File: rtl/lfsr_ctrl_pkg.sv
// lfsr_ctrl_pkg: shared types and constants for the LFSR sequencer.
//   LFSR_W       width of the shared LFSR
//   DEFAULT_SEED power-up seed, also used in place of an all-zero seed
//   state_t      controller state encoding
//   fix_seed()   replaces an all-zero seed with a fallback
package lfsr_ctrl_pkg;

    localparam int LFSR_W = 8;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'hA5;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DELIVER,
        ST_RECOVER
    } state_t;

    // An all-zero seed would lock the LFSR, so it is never loaded.
    function automatic logic [LFSR_W-1:0] fix_seed(input logic [LFSR_W-1:0] s,
                                                   input logic [LFSR_W-1:0] dflt);
        return (s == '0) ? dflt : s;
    endfunction

endpackage

// File: rtl/lfsr_ctrl_if.sv
// lfsr_ctrl_if: requester-side bus of the LFSR sequencer.
//   req       per-requester request level
//   grant     one-hot grant
//   rnd_valid one-cycle strobe, rnd_data valid
//   rnd_data  sampled LFSR value (held between strobes)
//   reseed    pulse: capture seed_in for a later reload
//   seed_in   new seed value
// Modports: master = requester side, slave = controller side.
interface lfsr_ctrl_if
    import lfsr_ctrl_pkg::*;
#(
    parameter int NREQ = 4
) ();
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   grant;
    logic              rnd_valid;
    logic [LFSR_W-1:0] rnd_data;
    logic              reseed;
    logic [LFSR_W-1:0] seed_in;

    modport master (output req, reseed, seed_in, input grant, rnd_valid, rnd_data);
    modport slave  (input req, reseed, seed_in, output grant, rnd_valid, rnd_data);
endinterface

// File: rtl/lfsr_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   i_req   request vector
//   i_ptr   index with highest priority this round
//   i_en    when low, no grant is produced
//   o_grant one-hot grant of the first requester at or after i_ptr
//   o_idx   encoded index of o_grant
//   o_found any requester granted
// The pointer register lives in the controller.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    input  logic             i_en,
    output logic [NREQ-1:0]  o_grant,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_found
);
    // Two passes: positions at/after the pointer first, then the wrapped ones.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_found = 1'b0;
        if (i_en) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!o_found && i_req[j] && (j >= int'(i_ptr))) begin
                    o_found    = 1'b1;
                    o_grant[j] = 1'b1;
                    o_idx      = PTR_W'(j);
                end
            end
            for (int j = 0; j < NREQ; j++) begin
                if (!o_found && i_req[j] && (j < int'(i_ptr))) begin
                    o_found    = 1'b1;
                    o_grant[j] = 1'b1;
                    o_idx      = PTR_W'(j);
                end
            end
        end
    end
endmodule

// File: rtl/lfsr_ctrl.sv
// lfsr_ctrl: round-robin sequencer for the shared 8-bit LFSR.
//   i_clock      clock, rising edge
//   i_rst        synchronous active-low reset
//   bus          lfsr_ctrl_if.slave (req/grant/rnd_valid/rnd_data/reseed/seed_in)
//   i_lfsr_q     LFSR state
//   o_lfsr_seed  LFSR seed input
//   o_lfsr_load  LFSR load (1 = load seed)
//   o_lfsr_stp   LFSR stall (1 = hold)
//   o_busy       high whenever the FSM is not in IDLE
// Optional macro LFSR_CTRL_LOCKUP_EN: a zero sample in DELIVER is not
// delivered; the LFSR is reloaded with SEED and the run repeats.
//
//   state   | meaning
//   INIT    | load SEED after reset
//   IDLE    | LFSR stalled; service reseed, else arbitrate
//   LOAD    | load captured seed
//   RUN     | LFSR advances STEPS cycles for the grant holder
//   DELIVER | strobe sample to the grant holder
//   RECOVER | reload SEED after a lockup, then RUN again
module lfsr_ctrl
    import lfsr_ctrl_pkg::*;
#(
    parameter int                NREQ  = 4,
    parameter int                STEPS = 8,
    parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED
) (
    input  logic              i_clock,
    input  logic              i_rst,
    lfsr_ctrl_if.slave        bus,
    input  logic [LFSR_W-1:0] i_lfsr_q,
    output logic [LFSR_W-1:0] o_lfsr_seed,
    output logic              o_lfsr_load,
    output logic              o_lfsr_stp,
    output logic              o_busy
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0] CNT_INIT = 8'(STEPS - 1);

    state_t            r_state;
    state_t            w_next;
    logic [NREQ-1:0]   r_grant;
    logic [PTR_W-1:0]  r_idx;
    logic [PTR_W-1:0]  r_ptr;
    logic [7:0]        r_cnt;
    logic [LFSR_W-1:0] r_seed;
    logic              r_pend;
    logic [LFSR_W-1:0] r_rnd_data;

    logic [NREQ-1:0]   w_arb_grant;
    logic [PTR_W-1:0]  w_arb_idx;
    logic              w_arb_found;
    logic              w_arb_en;
    logic              w_load;
    logic              w_stp;
    logic [LFSR_W-1:0] w_seed;
    logic              w_valid;
    logic [PTR_W-1:0]  w_ptr_next;

    // Pending reseed outranks requests in IDLE.
    assign w_arb_en   = (r_state == ST_IDLE) && !r_pend;
    assign w_ptr_next = (r_idx == PTR_W'(NREQ - 1)) ? '0 : r_idx + 1'b1;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .i_en    (w_arb_en),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_found (w_arb_found)
    );

    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_stp   = 1'b1;
        w_seed  = SEED;
        w_valid = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_load = 1'b1;
                w_stp  = 1'b0;
                w_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (r_pend)           w_next = ST_LOAD;
                else if (w_arb_found) w_next = ST_RUN;
            end
            ST_LOAD: begin
                w_load = 1'b1;
                w_stp  = 1'b0;
                w_seed = fix_seed(r_seed, SEED);
                w_next = ST_IDLE;
            end
            ST_RUN: begin
                w_stp = 1'b0;
                if (r_cnt == '0) w_next = ST_DELIVER;
            end
            ST_DELIVER: begin
`ifdef LFSR_CTRL_LOCKUP_EN
                if (i_lfsr_q == '0) begin
                    w_next = ST_RECOVER;
                end else begin
                    w_valid = 1'b1;
                    w_next  = ST_IDLE;
                end
`else
                w_valid = 1'b1;
                w_next  = ST_IDLE;
`endif
            end
`ifdef LFSR_CTRL_LOCKUP_EN
            ST_RECOVER: begin
                w_load = 1'b1;
                w_stp  = 1'b0;
                w_next = ST_RUN;
            end
`endif
            default: w_next = ST_INIT;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_rst) begin
            r_state    <= ST_INIT;
            r_grant    <= '0;
            r_idx      <= '0;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_seed     <= SEED;
            r_pend     <= 1'b0;
            r_rnd_data <= '0;
        end else begin
            r_state <= w_next;
            // A capture in the LOAD cycle itself stays pending (last capture wins).
            if (bus.reseed) begin
                r_seed <= bus.seed_in;
                r_pend <= 1'b1;
            end else if (r_state == ST_LOAD) begin
                r_pend <= 1'b0;
            end
            if (w_arb_found) begin
                r_grant <= w_arb_grant;
                r_idx   <= w_arb_idx;
                r_cnt   <= CNT_INIT;
            end else if ((r_state == ST_RUN) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
`ifdef LFSR_CTRL_LOCKUP_EN
            else if (r_state == ST_RECOVER) begin
                r_cnt <= CNT_INIT;
            end
`endif
            if (w_valid) begin
                r_rnd_data <= i_lfsr_q;
                r_grant    <= '0;
                r_ptr      <= w_ptr_next;
            end
        end
    end

    // While reset is held the FSM sits in INIT, but the LFSR must stay
    // stalled and unloaded until reset is released.
    assign o_lfsr_load   = w_load & i_rst;
    assign o_lfsr_stp    = w_stp | ~i_rst;
    assign o_lfsr_seed   = w_seed;
    assign o_busy        = (r_state != ST_IDLE);
    assign bus.grant     = r_grant;
    assign bus.rnd_valid = w_valid;
    // The LFSR is stalled in DELIVER, so its output is stable for the strobe.
    assign bus.rnd_data  = w_valid ? i_lfsr_q : r_rnd_data;

endmodule

// File: tb/tb_lfsr_ctrl.sv
// tb_lfsr_ctrl: wraps lfsr_ctrl with a model of the team LFSR (taps 7,3,2,1,
// left shift, load/stall active high, load only while not stalled).
// Build with LFSR_CTRL_LOCKUP_EN to exercise the lockup recovery path.
module tb_lfsr_ctrl;
    import lfsr_ctrl_pkg::*;

    localparam int NREQ  = 4;
    localparam int STEPS = 8;

    typedef struct packed {
        logic [NREQ-1:0] grant;
        logic [7:0]      data;
    } exp_t;

    typedef struct {
        logic [NREQ-1:0] req;
        logic [NREQ-1:0] grant;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] lfsr_r;
    logic [7:0] lfsr_q_drv;
    logic [7:0] lfsr_seed;
    logic       lfsr_load;
    logic       lfsr_stp;
    logic       busy;
    logic       force_zero;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [7:0] sw;
    int   cyc = 0;
    int   hold = 0;
    int   last_v = -1;
    bit   chk_gap = 1'b0;
    bit   chk_hold = 1'b1;

    always #5 clk = ~clk;

    lfsr_ctrl_if #(.NREQ(NREQ)) bus ();

    lfsr_ctrl #(
        .NREQ  (NREQ),
        .STEPS (STEPS),
        .SEED  (8'hA5)
    ) dut (
        .i_clock     (clk),
        .i_rst       (rst),
        .bus         (bus),
        .i_lfsr_q    (lfsr_q_drv),
        .o_lfsr_seed (lfsr_seed),
        .o_lfsr_load (lfsr_load),
        .o_lfsr_stp  (lfsr_stp),
        .o_busy      (busy)
    );

    always_ff @(posedge clk) begin
        if (!lfsr_stp) begin
            if (lfsr_load) lfsr_r <= lfsr_seed;
            else           lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[3] ^ lfsr_r[2] ^ lfsr_r[1]};
        end
    end

    assign lfsr_q_drv = force_zero ? 8'h00 : lfsr_r;

    function automatic logic [7:0] step_n(input logic [7:0] v, input int n);
        logic [7:0] s;
        s = v;
        for (int k = 0; k < n; k++) s = {s[6:0], s[7] ^ s[3] ^ s[2] ^ s[1]};
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_sample(input logic [NREQ-1:0] g);
        exp_t e;
        sw      = step_n(sw, STEPS);
        e.grant = g;
        e.data  = sw;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_pending"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_load(input string name, input bit with_grant, output bit found);
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (lfsr_load && ((bus.grant != '0) == with_grant)) found = 1'b1;
        end
        chk({name, "_seen"}, 32'(found), 32'd1);
    endtask

    // Scoreboard: every strobe must match the oldest expected sample.
    always @(negedge clk) begin : mon
        exp_t e;
        cyc++;
        if (bus.grant != '0) hold++;
        else                 hold = 0;
        if (bus.rnd_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got rnd_data %0h grant %0h expected no strobe",
                         bus.rnd_data, bus.grant);
            end else begin
                e = sb.pop_front();
                chk("sample_grant", 32'(bus.grant), 32'(e.grant));
                chk("sample_data", 32'(bus.rnd_data), 32'(e.data));
                if (chk_hold) chk("grant_hold", 32'(hold), 32'(STEPS + 1));
                if (chk_gap && last_v >= 0) chk("strobe_gap", 32'(cyc - last_v), 32'(STEPS + 2));
            end
            last_v = cyc;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[12];
        bit   found;
        int   nload;

        rst         = 1'b0;
        bus.req     = '0;
        bus.reseed  = 1'b0;
        bus.seed_in = 8'h00;
        force_zero  = 1'b0;

        vt[0]  = '{4'b0001, 4'b0001};
        vt[1]  = '{4'b0001, 4'b0001};
        vt[2]  = '{4'b1010, 4'b0010};
        vt[3]  = '{4'b1010, 4'b1000};
        vt[4]  = '{4'b0110, 4'b0010};
        vt[5]  = '{4'b0101, 4'b0100};
        vt[6]  = '{4'b1000, 4'b1000};
        vt[7]  = '{4'b1111, 4'b0001};
        vt[8]  = '{4'b1111, 4'b0010};
        vt[9]  = '{4'b1111, 4'b0100};
        vt[10] = '{4'b1111, 4'b1000};
        vt[11] = '{4'b1111, 4'b0001};

        // Reset held
        repeat (2) @(negedge clk);
        chk("rst0_grant", 32'(bus.grant), 32'd0);
        chk("rst0_valid", 32'(bus.rnd_valid), 32'd0);
        chk("rst0_data", 32'(bus.rnd_data), 32'd0);
        chk("rst0_load", 32'(lfsr_load), 32'd0);
        chk("rst0_stp", 32'(lfsr_stp), 32'd1);
        chk("rst0_seed", 32'(lfsr_seed), 32'hA5);
        chk("rst0_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("init_load", 32'(lfsr_load), 32'd1);
        chk("init_stp", 32'(lfsr_stp), 32'd0);
        chk("init_seed", 32'(lfsr_seed), 32'hA5);
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_stp", 32'(lfsr_stp), 32'd1);
        chk("idle_load", 32'(lfsr_load), 32'd0);
        sw = 8'hA5;

        // Arbitration table, back-to-back deliveries
        chk_gap = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.req = vt[i].req;
            expect_sample(vt[i].grant);
            wait_drain($sformatf("vec%0d", i), 40);
            if (i == 0) chk("first_sample", 32'(bus.rnd_data), 32'h12);
        end
        chk_gap = 1'b0;
        bus.req = '0;

        // Zero reseed during RUN: delivery completes, then LOAD with SEED
        repeat (3) @(negedge clk);
        bus.req = 4'b0001;
        expect_sample(4'b0001);
        repeat (3) @(negedge clk);
        bus.reseed  = 1'b1;
        bus.seed_in = 8'h00;
        @(negedge clk);
        bus.reseed = 1'b0;
        sw = 8'hA5;
        expect_sample(4'b0001);
        wait_load("rs0_load", 1'b0, found);
        chk("rs0_seed", 32'(lfsr_seed), 32'hA5);
        chk("rs0_stp", 32'(lfsr_stp), 32'd0);
        chk("rs0_busy", 32'(busy), 32'd1);
        chk("rs0_order", 32'(sb.size()), 32'd1);
        wait_drain("rs0", 60);
        bus.req = '0;
        repeat (3) @(negedge clk);
        chk("data_hold", 32'(bus.rnd_data), 32'h12);

        // Reseed 3C pending together with a request: LOAD before the grant
        bus.req = 4'b0010;
        expect_sample(4'b0010);
        repeat (3) @(negedge clk);
        bus.reseed  = 1'b1;
        bus.seed_in = 8'h3C;
        @(negedge clk);
        bus.reseed = 1'b0;
        sw = 8'h3C;
        expect_sample(4'b0010);
        wait_load("rs3c_load", 1'b0, found);
        chk("rs3c_seed", 32'(lfsr_seed), 32'h3C);
        chk("rs3c_busy", 32'(busy), 32'd1);
        chk("rs3c_order", 32'(sb.size()), 32'd1);
        wait_drain("rs3c", 60);
        bus.req = '0;

        // Reset in the middle of RUN, with a reseed pending
        repeat (2) @(negedge clk);
        bus.req = 4'b0100;
        @(negedge clk);
        bus.reseed  = 1'b1;
        bus.seed_in = 8'h5A;
        @(negedge clk);
        bus.reseed = 1'b0;
        @(negedge clk);
        rst     = 1'b0;
        bus.req = '0;
        @(negedge clk);
        chk("rst1_grant", 32'(bus.grant), 32'd0);
        chk("rst1_valid", 32'(bus.rnd_valid), 32'd0);
        chk("rst1_stp", 32'(lfsr_stp), 32'd1);
        chk("rst1_load", 32'(lfsr_load), 32'd0);
        chk("rst1_data", 32'(bus.rnd_data), 32'd0);
        rst = 1'b1;
        #1;
        chk("rinit_load", 32'(lfsr_load), 32'd1);
        chk("rinit_seed", 32'(lfsr_seed), 32'hA5);
        sw    = 8'hA5;
        nload = 0;
        repeat (15) begin
            @(negedge clk);
            if (lfsr_load) nload++;
        end
        chk("no_stale_load", 32'(nload), 32'd0);
        chk("rst_idle_busy", 32'(busy), 32'd0);
        bus.req = 4'b0001;
        expect_sample(4'b0001);
        wait_drain("post_rst", 40);
        bus.req = '0;

        // Zero sample at DELIVER
        repeat (2) @(negedge clk);
`ifdef LFSR_CTRL_LOCKUP_EN
        bus.req    = 4'b0010;
        force_zero = 1'b1;
        chk_hold   = 1'b0;
        sw = 8'hA5;
        expect_sample(4'b0010);
        wait_load("recover_load", 1'b1, found);
        chk("recover_seed", 32'(lfsr_seed), 32'hA5);
        chk("recover_grant", 32'(bus.grant), 32'b0010);
        chk("recover_stp", 32'(lfsr_stp), 32'd0);
        force_zero = 1'b0;
        wait_drain("recover", 60);
        bus.req  = '0;
        chk_hold = 1'b1;
`else
        begin
            exp_t ez;
            bus.req    = 4'b0010;
            force_zero = 1'b1;
            ez.grant   = 4'b0010;
            ez.data    = 8'h00;
            sb.push_back(ez);
            sw = step_n(sw, STEPS);
            wait_drain("zero_sample", 40);
            force_zero = 1'b0;
            bus.req    = '0;
        end
`endif

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
